vga_dither_out: RTL and testbench
=================================

# vga_dither_out

Output stage between the `system` core's 6-bit-per-channel VGA video and the 3-bit-per-channel board DAC pins. It replaces plain truncation (keeping bits [5:3]) with 4×4 ordered (Bayer) dithering, with optional temporal variation per frame. It derives pixel and line phase from the incoming syncs and a pixel-enable. It delays HSYNC/VSYNC by the same amount as the colour pipeline so the raster stays aligned.

## Interface
Parameters:
- `IN_W`, 6, input bits per colour channel.
- `OUT_W`, 3, output bits per channel. `IN_W-OUT_W` must equal 3.
- `SYNC_ACT`, 0, active level of both HSYNC and VSYNC (0 = active-low).
- `TEMPORAL`, 1. When 1, the matrix index is perturbed by a 2-bit frame counter.

Ports:
- `clk_vga` in 1: video clock, 28.571 MHz. All logic is on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `pix_ce` in 1: pixel-enable; one pulse per displayed pixel.
- `dither_en` in 1: 1 = dither, 0 = truncate. Sampled per pixel.
- `r_in`, `g_in`, `b_in` in `IN_W`: colour from `system`.
- `hsync_in`, `vsync_in` in 1: syncs from `system`.
- `r_out`, `g_out`, `b_out` out `OUT_W`: to `VGA_R/G/B`.
- `hsync_out`, `vsync_out` out 1: to `VGA_HSYNC/VGA_VSYNC`.

## Operation
- **Edge detection.** Register the syncs. An active edge is the transition from inactive to `SYNC_ACT`.
- **`x[1:0]`.**
  - Increments, with wrap, on each `pix_ce`.
  - Cleared on an hsync active edge. The clear wins over a same-cycle `pix_ce`.
- **`y[1:0]`.**
  - Increments on an hsync active edge.
  - Cleared on a vsync active edge. The clear wins when both edges occur in the same cycle.
- **`frame[1:0]`.** Increments on each vsync active edge. It only affects the index when `TEMPORAL`=1.
- **Matrix index.** `ix = x ^ {frame[0],frame[0]}` and `iy = y ^ {frame[1],frame[1]}` when `TEMPORAL`=1; otherwise `ix=x`, `iy=y`.
- **Threshold.** `t = bayer[iy][ix] >> 1`, range 0..7. Rows of `bayer` are {0,8,2,10}, {12,4,14,6}, {3,11,1,9}, {15,7,13,5}.
- **Per channel, dither on.**
  - `hi = in[5:3]`, `lo = in[2:0]`.
  - `out = hi + (lo > t)`, saturating at 7. The add is 4-bit internally, then clamped.
  - Input 0 always gives 0; input 63 always gives 7.
- **Per channel, dither off.** `out = in[5:3]`.
- **Independence.** All three channels share the same `t`.

## Timing
- **Latency.** Fixed 2 `clk_vga` cycles from inputs (colour, syncs, `dither_en`) to outputs, independent of `pix_ce`.
  - Stage 1 registers the inputs and the threshold.
  - Stage 2 registers the result and the delayed syncs.
- **Counter updates.** Counters update in stage 1, using the edge detected from the registered sync. The threshold applied to a pixel is the one for the counter value before that cycle's update.
- **Reset.**
  - Every output returns to its reset value on the first clock with `rst_n`=0 and holds there while low.
  - Reset values: `r_out/g_out/b_out` = 0; `hsync_out`/`vsync_out` = `~SYNC_ACT` (inactive); `x`, `y`, `frame` = 0; sync history = inactive.
- **Reset mid-frame.** After release, outputs carry valid pixels 2 cycles later. Phase is arbitrary until the next hsync/vsync edge. No spurious edge is detected, because the history resets to inactive.
- **No pixel-enable.** `pix_ce` stuck low leaves `x` frozen; the colour path keeps flowing.
- **Sync edges.** Syncs pass unmodified, with no glitch filtering; their pulse widths are preserved exactly.

## Structure
- **Package `vga_dither_pkg`.** Holds the `IN_W`/`OUT_W` defaults, the `bayer` 4×4 constant array (4-bit entries) and a `sat_add` function.
- **Sub-module `bayer4x4_lut`.** Combinational: `ix`, `iy`, `temporal`, `frame` → `t[2:0]`.
- **Channel datapath.** A generate loop over the three channels, inside `vga_dither_out`.

## Test plan
- **Reset.** Hold `rst_n`=0 for 3 cycles with `r_in`=63 → `r_out`=0 and syncs = 1 (with `SYNC_ACT`=0). After release, `r_out`=7 exactly 2 cycles later.
- **Flat mid-grey.** Constant 36 (`hi`=4, `lo`=4), `TEMPORAL`=0, `pix_ce` every cycle → over a 4×4 block, the count of 5s equals the count of `t`<4, which is 8. The remainder are 4.
- **Saturation and black.**
  - Input 63, all positions → always 7.
  - Input 0 → always 0.
  - Input 7 at a position with `t`=0 → 1.
- **Bypass.** `dither_en`=0 with input 45 → 5 at every position; latency is still 2.
- **Simultaneous edges.** hsync and vsync active edges in the same cycle → `y`=0, `x`=0, `frame` increments by 1. The next pixel uses `bayer[0][0]`, or the `frame`-xored index when `TEMPORAL`=1.
- **Sync alignment.** A 96-cycle hsync pulse in → an identical 96-cycle pulse out, delayed exactly 2 cycles.

Source files
------------

// File: rtl/vga_dither_pkg.sv
// Shared constants and helpers for the VGA 4x4 ordered-dither output stage.
package vga_dither_pkg;

  localparam int DEF_IN_W  = 6;
  localparam int DEF_OUT_W = 3;
  localparam int N_CH      = 3;

  // Classic 4x4 Bayer matrix, indexed [row][column].
  localparam logic [3:0] BAYER [0:3][0:3] = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6 },
    '{4'd3,  4'd11, 4'd1,  4'd9 },
    '{4'd15, 4'd7,  4'd13, 4'd5 }
  };

  function automatic logic [2:0] sat_add(input logic [2:0] hi, input logic inc);
    logic [3:0] sum;
    logic [2:0] res;
    sum = {1'b0, hi} + {3'b000, inc};
    if (sum[3]) begin
      res = 3'd7;
    end else begin
      res = sum[2:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/vga_dither_out_bayer4x4_lut.sv
// Bayer threshold lookup: pixel/line phase (optionally frame-perturbed) to a 0..7 threshold.
module bayer4x4_lut
  import vga_dither_pkg::*;
(
  input  logic [1:0] i_ix,
  input  logic [1:0] i_iy,
  input  logic       i_temporal,
  input  logic [1:0] i_frame,
  output logic [2:0] o_t
);

  logic [1:0] w_ix;
  logic [1:0] w_iy;
  logic [3:0] w_entry;

  // Index selection and matrix read; the matrix entry is halved to get 0..7.
  always_comb begin
    w_ix = i_ix;
    w_iy = i_iy;
    if (i_temporal) begin
      w_ix = i_ix ^ {2{i_frame[0]}};
      w_iy = i_iy ^ {2{i_frame[1]}};
    end else begin
      w_ix = i_ix;
      w_iy = i_iy;
    end
    w_entry = BAYER[w_iy][w_ix];
    o_t     = w_entry[3:1];
  end

endmodule

// File: rtl/vga_dither_out.sv
// VGA output stage: 6-bit colour to 3-bit DAC pins with 4x4 ordered dithering,
// syncs delayed to match the two-stage colour pipeline.
module vga_dither_out
  import vga_dither_pkg::*;
#(
  parameter int   IN_W     = DEF_IN_W,
  parameter int   OUT_W    = DEF_OUT_W,
  parameter logic SYNC_ACT = 1'b0,
  parameter logic TEMPORAL = 1'b1
) (
  input  logic             clk_vga,
  input  logic             rst_n,
  input  logic             pix_ce,
  input  logic             dither_en,
  input  logic [IN_W-1:0]  r_in,
  input  logic [IN_W-1:0]  g_in,
  input  logic [IN_W-1:0]  b_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  output logic [OUT_W-1:0] r_out,
  output logic [OUT_W-1:0] g_out,
  output logic [OUT_W-1:0] b_out,
  output logic             hsync_out,
  output logic             vsync_out
);

  logic              r_hs1;
  logic              r_vs1;
  logic              r_hs_hist;
  logic              r_vs_hist;
  logic              r_den1;
  logic [2:0]        r_t;
  logic [IN_W-1:0]   r_pix1 [N_CH];
  logic [1:0]        r_x;
  logic [1:0]        r_y;
  logic [1:0]        r_frame;
  logic [OUT_W-1:0]  r_res  [N_CH];
  logic              r_hs2;
  logic              r_vs2;

  logic              w_hs_edge;
  logic              w_vs_edge;
  logic [1:0]        w_x_nxt;
  logic [1:0]        w_y_nxt;
  logic [1:0]        w_frame_nxt;
  logic [2:0]        w_t;
  logic [IN_W-1:0]   w_pix_in [N_CH];
  logic [OUT_W-1:0]  w_res    [N_CH];

  assign w_pix_in[0] = r_in;
  assign w_pix_in[1] = g_in;
  assign w_pix_in[2] = b_in;

  // Edges come from the registered sync against its own history, so a reset
  // history of "inactive" can never fake an edge.
  assign w_hs_edge = (r_hs1 == SYNC_ACT) && (r_hs_hist != SYNC_ACT);
  assign w_vs_edge = (r_vs1 == SYNC_ACT) && (r_vs_hist != SYNC_ACT);

  // Phase counter next-state; clears take priority over increments.
  always_comb begin
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_frame_nxt = r_frame;
    if (w_hs_edge) begin
      w_x_nxt = 2'd0;
    end else if (pix_ce) begin
      w_x_nxt = r_x + 2'd1;
    end else begin
      w_x_nxt = r_x;
    end
    if (w_vs_edge) begin
      w_y_nxt     = 2'd0;
      w_frame_nxt = r_frame + 2'd1;
    end else if (w_hs_edge) begin
      w_y_nxt     = r_y + 2'd1;
      w_frame_nxt = r_frame;
    end else begin
      w_y_nxt     = r_y;
      w_frame_nxt = r_frame;
    end
  end

  bayer4x4_lut u_lut (
    .i_ix       (r_x),
    .i_iy       (r_y),
    .i_temporal (TEMPORAL),
    .i_frame    (r_frame),
    .o_t        (w_t)
  );

  // Stage 1: capture inputs, the threshold for the pre-update phase, and counters.
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      r_hs1     <= ~SYNC_ACT;
      r_vs1     <= ~SYNC_ACT;
      r_hs_hist <= ~SYNC_ACT;
      r_vs_hist <= ~SYNC_ACT;
      r_den1    <= 1'b0;
      r_t       <= 3'd0;
      r_x       <= 2'd0;
      r_y       <= 2'd0;
      r_frame   <= 2'd0;
      for (int c = 0; c < N_CH; c++) begin
        r_pix1[c] <= {IN_W{1'b0}};
      end
    end else begin
      r_hs1     <= hsync_in;
      r_vs1     <= vsync_in;
      r_hs_hist <= r_hs1;
      r_vs_hist <= r_vs1;
      r_den1    <= dither_en;
      r_t       <= w_t;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_frame   <= w_frame_nxt;
      for (int c = 0; c < N_CH; c++) begin
        r_pix1[c] <= w_pix_in[c];
      end
    end
  end

  // All channels share the same threshold; bypass keeps only the top bits.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [OUT_W-1:0]      w_hi;
    logic [IN_W-OUT_W-1:0] w_lo;
    assign w_hi     = r_pix1[g][IN_W-1 -: OUT_W];
    assign w_lo     = r_pix1[g][IN_W-OUT_W-1:0];
    assign w_res[g] = r_den1 ? sat_add(w_hi, (w_lo > r_t)) : w_hi;
  end

  // Stage 2: registered colour result and syncs delayed to match.
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      r_hs2 <= ~SYNC_ACT;
      r_vs2 <= ~SYNC_ACT;
      for (int c = 0; c < N_CH; c++) begin
        r_res[c] <= {OUT_W{1'b0}};
      end
    end else begin
      r_hs2 <= r_hs1;
      r_vs2 <= r_vs1;
      for (int c = 0; c < N_CH; c++) begin
        r_res[c] <= w_res[c];
      end
    end
  end

  assign r_out     = r_res[0];
  assign g_out     = r_res[1];
  assign b_out     = r_res[2];
  assign hsync_out = r_hs2;
  assign vsync_out = r_vs2;

endmodule

// File: tb/tb_vga_dither_out.sv
// Directed self-checking bench for vga_dither_out: one static-matrix and one temporal instance.
module tb_vga_dither_out;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_ce;
  logic       den;
  logic [5:0] r_i, g_i, b_i;
  logic       hs, vs;
  logic [2:0] r0, g0, b0, r1, g1, b1;
  logic       hs0, vs0, hs1, vs1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vga_dither_out #(.IN_W(6), .OUT_W(3), .SYNC_ACT(1'b0), .TEMPORAL(1'b0)) dut0 (
    .clk_vga(clk), .rst_n(rst_n), .pix_ce(pix_ce), .dither_en(den),
    .r_in(r_i), .g_in(g_i), .b_in(b_i), .hsync_in(hs), .vsync_in(vs),
    .r_out(r0), .g_out(g0), .b_out(b0), .hsync_out(hs0), .vsync_out(vs0)
  );

  vga_dither_out #(.IN_W(6), .OUT_W(3), .SYNC_ACT(1'b0), .TEMPORAL(1'b1)) dut1 (
    .clk_vga(clk), .rst_n(rst_n), .pix_ce(pix_ce), .dither_en(den),
    .r_in(r_i), .g_in(g_i), .b_in(b_i), .hsync_in(hs), .vsync_in(vs),
    .r_out(r1), .g_out(g1), .b_out(b1), .hsync_out(hs1), .vsync_out(vs1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_rgb(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b);
    r_i = r;
    g_i = g;
    b_i = b;
  endtask

  initial begin
    int c5_0, c4_0, c5_1, c4_1, oth, gbd;
    int cnt0, first0, last0, cnt1, first1, last1;

    // Reset held 3 cycles with full-scale colour and active syncs on the inputs.
    rst_n = 1'b0; pix_ce = 1'b0; den = 1'b1; hs = 1'b0; vs = 1'b0;
    set_rgb(6'd63, 6'd63, 6'd63);
    step(); step(); step();
    chk3("rst_r0", r0, 3'd0);
    chk3("rst_r1", r1, 3'd0);
    chk1("rst_hs0", hs0, 1'b1);
    chk1("rst_vs0", vs0, 1'b1);
    chk1("rst_vs1", vs1, 1'b1);

    // Release: 63 appears exactly two clocks later.
    rst_n = 1'b1; hs = 1'b1; vs = 1'b1;
    step();                                // slot 0
    chk3("rel_lat1", r0, 3'd0);
    step();                                // slot 1
    chk3("rel_lat2", r0, 3'd7);

    // One hsync pulse (y=1), then simultaneous hsync+vsync edges.
    pix_ce = 1'b1; hs = 1'b0;
    step();                                // slot 2
    hs = 1'b1;
    step(); step(); step();                // slots 3..5
    hs = 1'b0; vs = 1'b0;
    step();                                // slot 6
    hs = 1'b1; vs = 1'b1; set_rgb(6'd1, 6'd4, 6'd7);
    step();                                // slot 7
    chk1("sync_out_hs0", hs0, 1'b0);
    chk1("sync_out_vs0", vs0, 1'b0);
    chk1("sync_out_hs1", hs1, 1'b0);
    step();                                // slot 8 -> pixel 7: x3 y1 f0, t=3
    chk1("sync_back_hs0", hs0, 1'b1);
    chk3("p7_r0", r0, 3'd0); chk3("p7_g0", g0, 3'd1); chk3("p7_b0", b0, 3'd1);
    chk3("p7_g1", g1, 3'd1);
    step();                                // slot 9 -> pixel 8: x0 y0 f1
    chk3("p8_r0", r0, 3'd1); chk3("p8_g0", g0, 3'd1); chk3("p8_b0", b0, 3'd1);
    chk3("p8_r1", r1, 3'd0); chk3("p8_g1", g1, 3'd0); chk3("p8_b1", b1, 3'd1);
    step();                                // slot 10 -> pixel 9: x1 y0 f1
    chk3("p9_r0", r0, 3'd0); chk3("p9_g0", g0, 3'd0); chk3("p9_b0", b0, 3'd1);
    chk3("p9_r1", r1, 3'd0); chk3("p9_g1", g1, 3'd1); chk3("p9_b1", b1, 3'd1);

    // Flat mid-grey 36 over four lines of four pixels.
    set_rgb(6'd36, 6'd36, 6'd36);
    c5_0 = 0; c4_0 = 0; c5_1 = 0; c4_1 = 0; oth = 0; gbd = 0;
    for (int ln = 0; ln < 4; ln++) begin
      hs = 1'b0; step();
      hs = 1'b1; step();
      step();
      for (int k = 0; k < 4; k++) begin
        step();
        if (r0 == 3'd5) c5_0++; else if (r0 == 3'd4) c4_0++; else oth++;
        if (r1 == 3'd5) c5_1++; else if (r1 == 3'd4) c4_1++; else oth++;
        if ((g0 !== r0) || (b0 !== r0) || (g1 !== r1) || (b1 !== r1)) gbd++;
      end
    end
    chkn("grey_fives_t0", c5_0, 8);
    chkn("grey_fours_t0", c4_0, 8);
    chkn("grey_fives_t1", c5_1, 8);
    chkn("grey_fours_t1", c4_1, 8);
    chkn("grey_other", oth, 0);
    chkn("grey_chan_diff", gbd, 0);

    // Saturation: 63 always 7, then black always 0.
    set_rgb(6'd63, 6'd63, 6'd63);
    step(); step();
    for (int k = 0; k < 4; k++) begin
      step();
      chk3("sat_r0", r0, 3'd7); chk3("sat_b0", b0, 3'd7); chk3("sat_g1", g1, 3'd7);
    end
    set_rgb(6'd0, 6'd0, 6'd0);
    step(); step();
    for (int k = 0; k < 4; k++) begin
      step();
      chk3("blk_r0", r0, 3'd0); chk3("blk_r1", r1, 3'd0);
    end

    // Bypass with 45: 5 everywhere, still two-cycle latency.
    den = 1'b0; set_rgb(6'd45, 6'd45, 6'd45);
    step();
    chk3("byp_lat1", r0, 3'd0);
    step();
    chk3("byp_lat2", r0, 3'd5);
    for (int k = 0; k < 4; k++) begin
      step();
      chk3("byp_r0", r0, 3'd5); chk3("byp_g0", g0, 3'd5); chk3("byp_r1", r1, 3'd5);
    end
    den = 1'b1;

    // 96-cycle hsync pulse must come out identical, two cycles later.
    cnt0 = 0; first0 = -1; last0 = -1; cnt1 = 0; first1 = -1; last1 = -1;
    for (int n = 0; n < 110; n++) begin
      hs = (n >= 5 && n < 101) ? 1'b0 : 1'b1;
      step();
      if (hs0 == 1'b0) begin
        if (first0 < 0) first0 = n;
        last0 = n;
        cnt0++;
      end
      if (hs1 == 1'b0) begin
        if (first1 < 0) first1 = n;
        last1 = n;
        cnt1++;
      end
    end
    hs = 1'b1;
    chkn("hs_width0", cnt0, 96);
    chkn("hs_start0", first0, 6);
    chkn("hs_end0", last0, 101);
    chkn("hs_width1", cnt1, 96);
    chkn("hs_start1", first1, 6);
    chkn("hs_end1", last1, 101);

    // Mid-run reset takes effect on the first clock with rst_n low.
    set_rgb(6'd63, 6'd63, 6'd63); hs = 1'b0; vs = 1'b0;
    step(); step();
    chk3("pre_rst_r0", r0, 3'd7);
    chk1("pre_rst_hs0", hs0, 1'b0);
    rst_n = 1'b0;
    step();
    chk3("mid_rst_r0", r0, 3'd0);
    chk3("mid_rst_g1", g1, 3'd0);
    chk1("mid_rst_hs0", hs0, 1'b1);
    chk1("mid_rst_vs1", vs1, 1'b1);
    step(); step();
    chk3("mid_rst_hold_b0", b0, 3'd0);
    chk1("mid_rst_hold_hs1", hs1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
